// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbiter requester agent.
package arb_pkg;

  // Requester FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } arb_state_e;

  localparam int ARB_LEN_W_DEF   = 4;
  localparam int ARB_DATA_W_DEF  = 8;
  localparam int ARB_TIMEOUT_DEF = 16;

  // Job layout in the FIFO: length in the upper bits, base data below.
  typedef struct packed {
    logic [ARB_LEN_W_DEF-1:0]  len;
    logic [ARB_DATA_W_DEF-1:0] data;
  } arb_job_t;

endpackage

// File: rtl/arb_job_fifo.sv
// Synchronous job FIFO: push is dropped when full, pop is ignored when empty.
module arb_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Client-side arbiter agent: queues jobs, requests the bus, streams bursts,
// releases request for one cycle between jobs, aborts on grant timeout.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = ARB_LEN_W_DEF,
  parameter int DATA_W  = ARB_DATA_W_DEF,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [DATA_W-1:0] job_data,
  output logic              request,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              timeout_err
);

  localparam int JOB_W  = LEN_W + DATA_W;
  localparam int WAIT_W = $clog2(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              request_q, request_d;
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_last_q, bus_last_d;
  logic              timeout_err_q, timeout_err_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic [JOB_W-1:0]  fifo_head_s;
  logic [LEN_W-1:0]  head_len_s;
  logic [DATA_W-1:0] head_data_s;

  // job_ready is plain !full: a pop in the same cycle does not free a slot early.
  assign job_ready   = !fifo_full_s;
  assign head_len_s  = fifo_head_s[DATA_W +: LEN_W];
  assign head_data_s = fifo_head_s[DATA_W-1:0];

  arb_job_fifo #(
    .DEPTH (DEPTH),
    .W     (JOB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid),
    .pop   (fifo_pop_s),
    .din   ({job_len, job_data}),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  assign request     = request_q;
  assign bus_valid   = bus_valid_q;
  assign bus_data    = bus_data_q;
  assign bus_last    = bus_last_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE) || !fifo_empty_s;

  // Next-state and next-output logic; beat_q is the index of the next beat to emit.
  always_comb begin
    state_d       = state_q;
    request_d     = request_q;
    bus_valid_d   = 1'b0;
    bus_data_d    = bus_data_q;
    bus_last_d    = 1'b0;
    timeout_err_d = 1'b0;
    beat_d        = beat_q;
    wait_d        = wait_q;
    fifo_pop_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_d   = REQ;
          request_d = 1'b1;
          wait_d    = '0;
        end else begin
          state_d   = IDLE;
          request_d = 1'b0;
        end
      end
      REQ: begin
        request_d = 1'b1;
        if (grant) begin
          bus_valid_d = 1'b1;
          bus_data_d  = head_data_s;
          wait_d      = '0;
          if (head_len_s == '0) begin
            // Single-beat job finishes on the grant edge itself.
            bus_last_d = 1'b1;
            fifo_pop_s = 1'b1;
            request_d  = 1'b0;
            beat_d     = '0;
            state_d    = REL;
          end else begin
            beat_d  = LEN_W'(1);
            state_d = XFER;
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          fifo_pop_s    = 1'b1;
          timeout_err_d = 1'b1;
          request_d     = 1'b0;
          wait_d        = '0;
          state_d       = REL;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      XFER: begin
        request_d = 1'b1;
        if (grant) begin
          bus_valid_d = 1'b1;
          bus_data_d  = head_data_s + DATA_W'(beat_q);
          if (beat_q == head_len_s) begin
            bus_last_d = 1'b1;
            fifo_pop_s = 1'b1;
            request_d  = 1'b0;
            beat_d     = '0;
            state_d    = REL;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end else begin
          // Grant withdrawn: pause with beat index held and request kept high.
          beat_d = beat_q;
        end
      end
      REL: begin
        // The cycle spent here is the single request-low gap; a queued job
        // re-raises request on the very next edge.
        if (!fifo_empty_s) begin
          state_d   = REQ;
          request_d = 1'b1;
          wait_d    = '0;
        end else begin
          state_d   = IDLE;
          request_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        request_d = 1'b0;
        beat_d    = '0;
        wait_d    = '0;
      end
    endcase
  end

  // State, counter and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      request_q     <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_data_q    <= '0;
      bus_last_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      beat_q        <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      request_q     <= request_d;
      bus_valid_q   <= bus_valid_d;
      bus_data_q    <= bus_data_d;
      bus_last_q    <= bus_last_d;
      timeout_err_q <= timeout_err_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a beat scoreboard.
module tb_arb_requester;

  logic       clk;
  logic       rst;
  logic       job_valid;
  logic       job_ready;
  logic [3:0] job_len;
  logic [7:0] job_data;
  logic       request;
  logic       grant;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_last;
  logic       busy;
  logic       timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  arb_requester #(
    .DEPTH   (4),
    .LEN_W   (4),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_len     (job_len),
    .job_data    (job_data),
    .request     (request),
    .grant       (grant),
    .bus_valid   (bus_valid),
    .bus_data    (bus_data),
    .bus_last    (bus_last),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one job; queue its expected beats only if it will be accepted and granted.
  task automatic push_job(input logic [3:0] len, input logic [7:0] data, input bit expect_beats);
    beat_t b;
    job_len   = len;
    job_data  = data;
    job_valid = 1'b1;
    if (job_ready && expect_beats) begin
      for (int k = 0; k <= int'(len); k++) begin
        b.data = 8'(int'(data) + k);
        b.last = (k == int'(len));
        exp_q.push_back(b);
      end
    end
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles);
    for (int i = 0; i < max_cycles && request !== 1'b1; i++) tick();
    check("req_rise", request, 1);
  endtask

  // Grant-follows-request arbiter until the agent goes idle; checks request gaps.
  task automatic drain(input int max_cycles, output int nvalid, output int nlast);
    int gap = 0;
    bit prev_req;
    bit seen_fall = 1'b0;
    bit timed_out = 1'b1;
    prev_req = request;
    nvalid = 0;
    nlast  = 0;
    for (int i = 0; i < max_cycles; i++) begin
      grant = request;
      tick();
      if (bus_valid) nvalid++;
      if (bus_valid && bus_last) nlast++;
      if (prev_req && !request) begin
        seen_fall = 1'b1;
        gap = 0;
      end
      if (!request) gap++;
      if (!prev_req && request && seen_fall) check("req_gap", gap, 1);
      prev_req = request;
      if (!busy && !bus_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    grant = 1'b0;
    check("drain_done", timed_out, 0);
  endtask

  // Scoreboard: every valid beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b1 && bus_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {23'd0, bus_data, bus_last}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus_data, e.data);
        check("beat_last", bus_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int nl;
    rst       = 1'b0;
    grant     = 1'b0;
    job_valid = 1'b0;
    job_len   = 4'd0;
    job_data  = 8'd0;
    tick();
    tick();
    check("rst_request", request, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_data", bus_data, 0);
    check("rst_bus_last", bus_last, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_job_ready", job_ready, 1);
    rst = 1'b1;
    tick();

    // Single-beat job, grant one cycle after request.
    push_job(4'd0, 8'h5A, 1'b1);
    check("t1_req_push_edge", request, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_req_rise", request, 1);
    grant = 1'b1;
    tick();
    check("t1_valid", bus_valid, 1);
    check("t1_last", bus_last, 1);
    check("t1_req_drop", request, 0);
    grant = 1'b0;
    tick();
    check("t1_rel_req", request, 0);
    check("t1_rel_valid", bus_valid, 0);
    check("t1_idle_busy", busy, 0);
    tick();
    check("t1_stay_low", request, 0);

    // Four beats with data wrap, grant held.
    push_job(4'd3, 8'hFE, 1'b1);
    drain(100, nv, nl);
    check("t2_nvalid", nv, 4);
    check("t2_nlast", nl, 1);

    // Same job with a two-cycle grant pause after beat 1.
    push_job(4'd3, 8'hFE, 1'b1);
    wait_req(10);
    grant = 1'b1;
    tick();
    check("t3_b0_valid", bus_valid, 1);
    tick();
    check("t3_b1_valid", bus_valid, 1);
    grant = 1'b0;
    tick();
    check("t3_pause1_valid", bus_valid, 0);
    check("t3_pause1_req", request, 1);
    tick();
    check("t3_pause2_valid", bus_valid, 0);
    check("t3_pause2_req", request, 1);
    grant = 1'b1;
    tick();
    check("t3_b2_valid", bus_valid, 1);
    tick();
    check("t3_b3_last", bus_last, 1);
    check("t3_b3_req", request, 0);
    grant = 1'b0;
    tick();
    tick();
    check("t3_idle", busy, 0);

    // Timeout on the first job, second job then served after one gap cycle.
    push_job(4'd0, 8'h11, 1'b0);
    push_job(4'd1, 8'h20, 1'b1);
    check("t4_req_rise", request, 1);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("t4_no_timeout", timeout_err, 0);
      check("t4_req_held", request, 1);
    end
    tick();
    check("t4_timeout_pulse", timeout_err, 1);
    check("t4_req_drop", request, 0);
    tick();
    check("t4_pulse_end", timeout_err, 0);
    check("t4_next_req", request, 1);
    drain(100, nv, nl);
    check("t4_nvalid", nv, 2);
    check("t4_nlast", nl, 1);

    // Overfill: fifth job is dropped, four bursts drain with one-cycle gaps.
    push_job(4'd1, 8'h30, 1'b1);
    push_job(4'd0, 8'h40, 1'b1);
    push_job(4'd2, 8'h50, 1'b1);
    push_job(4'd1, 8'h60, 1'b1);
    check("t5_full", job_ready, 0);
    push_job(4'd3, 8'h70, 1'b1);
    check("t5_still_full", job_ready, 0);
    check("t5_busy", busy, 1);
    drain(200, nv, nl);
    check("t5_nvalid", nv, 8);
    check("t5_bursts", nl, 4);
    check("t5_ready_again", job_ready, 1);

    // Reset asserted during beat 2 of a 4-beat burst with a job queued behind it.
    push_job(4'd3, 8'h80, 1'b1);
    push_job(4'd0, 8'h90, 1'b0);
    check("t6_req", request, 1);
    grant = 1'b1;
    tick();
    tick();
    tick();
    check("t6_beat2_valid", bus_valid, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_req", request, 0);
    check("t6_rst_valid", bus_valid, 0);
    check("t6_rst_last", bus_last, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_unsent_beats", exp_q.size(), 1);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_post_valid", bus_valid, 0);
      check("t6_post_req", request, 0);
    end
    check("t6_post_busy", busy, 0);
    grant = 1'b0;
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
